busmatrix_output_stage_rr2: RTL and testbench
=============================================

Name: busmatrix_output_stage_rr2

Overview:
Bus-matrix output stage for one AHB-Lite slave (MI) port, shared by two input-stage decoders (op0, op1). It is the far end of each decoder's per-port sel/active handshake. Each cycle it arbitrates between the two requesters and forwards the winner's address phase to the slave. It tracks the data-phase owner so write data is routed correctly, and it reports ownership back to each decoder via active_opN.

Parameters:
ARB_RR, 1, 1 = round-robin between op0/op1; 0 = fixed priority, op0 highest

Ports:
HCLK  input  1  AHB clock
HRESETn  input  1  asynchronous active-low reset
sel_op0, sel_op1  input  1  port request from decoder N (decoder's sel_decX for this MI)
addr_op0, addr_op1  input  32  HADDR from input stage N
trans_op0, trans_op1  input  2  HTRANS from input stage N
write_op0, write_op1  input  1  HWRITE
size_op0, size_op1  input  3  HSIZE
burst_op0, burst_op1  input  3  HBURST
prot_op0, prot_op1  input  4  HPROT
mastlock_op0, mastlock_op1  input  1  HMASTLOCK
wdata_op0, wdata_op1  input  32  HWDATA (data phase)
active_op0, active_op1  output  1  input N owns this port's address phase
HSELM  output  1  slave select
HADDRM  output  32  slave address
HTRANSM  output  2  slave HTRANS
HWRITEM, HSIZEM[3], HBURSTM[3], HPROTM[4], HMASTLOCKM  output  -  slave controls, muxed from owner
HWDATAM  output  32  write data, muxed by data-phase owner
HREADYMUXM  output  1  HREADY to slave
HREADYOUTM  input  1  slave HREADYOUT

Behaviour:
- Reset is HRESETn, asynchronous, active-low; clock is HCLK.
- Reset values:
  - addr_owner = none; data_owner = none; last_grant = op1, so op0 wins the first tie.
  - Outputs: active_op* = 0, HSELM = 0, HTRANSM = IDLE (00), HADDRM and other controls = 0, HWDATAM = 0.
- State:
  - addr_owner ∈ {none, op0, op1}, registered.
  - data_owner ∈ {none, op0, op1}, registered.
  - last_grant: 1 bit.
- Combinational next-owner selection:
  - Hold: keep addr_owner when the current owner's sel is high AND any of the following holds:
    - trans_owner is SEQ or BUSY (burst continuation), or
    - mastlock_owner = 1, or
    - HREADYOUTM = 0 (current address phase not yet accepted).
  - Otherwise, with exactly one requester, that requester wins.
  - Otherwise, with two requesters: if ARB_RR = 1, grant the port ≠ last_grant; if ARB_RR = 0, grant op0.
  - Otherwise, no requester: none.
- addr_owner <= next-owner on every posedge where HREADYOUTM = 1. last_grant updates only when a new grant occurs while both were requesting.
- Arbitration for the current cycle uses the combinational next-owner:
  - active_opN = (next_owner == N). Zero-latency, same cycle as sel_opN.
  - A decoder whose request is not granted sees active = 0. It holds the transfer in its own holding register. That is not this block's concern.
- Address outputs:
  - next_owner = none: HSELM = 0, HTRANSM = IDLE, other controls hold the last owner's values.
  - Otherwise: all signals come from next_owner. HSELM = 1.
- Data phase:
  - data_owner <= (HSELM & HTRANSM[1]) ? next_owner : none on posedge when HREADYOUTM = 1.
  - HWDATAM = wdata of data_owner; 0 when none.
- HREADYMUXM = HREADYOUTM (direct); this block never adds wait states.
- Ownership change with the old data phase still in progress:
  - The new address phase is issued while the old owner's data phase completes.
  - HWDATAM stays with the old owner until HREADYOUTM = 1.
- Locked sequence: the owner is held while sel remains high, even with IDLE trans. Release occurs on the first cycle with mastlock = 0 or sel = 0.
- BUSY within a burst: ownership is held and HTRANSM = BUSY is forwarded.
- Reset asserted mid-burst: immediate return to reset values. No partial transfer is forwarded.
- sel_opN high with trans IDLE counts as a request. It produces HSELM = 1, HTRANSM = IDLE, which the slave answers with a zero-wait OKAY.

Test Plan:
- Reset, then both sel idle → HSELM = 0, HTRANSM = 00, active_op0 = active_op1 = 0, HWDATAM = 0.
- op0 single NONSEQ write to 0x40000010 with wdata 0xA5A5A5A5, HREADYOUTM = 1 → cycle0: active_op0 = 1, HADDRM = 0x40000010; cycle1: HWDATAM = 0xA5A5A5A5.
- ARB_RR = 1, both requesting single NONSEQ every cycle → grants alternate op0, op1, op0, op1; neither active asserted twice in a row.
- op0 INCR4 burst (NONSEQ, SEQ×3) with op1 requesting from beat 2 → op0 holds all 4 beats; op1 granted on beat 5.
- HREADYOUTM = 0 for 2 cycles during op1's data phase while op0 requests → addr_owner unchanged, HWDATAM = wdata_op1 until HREADYOUTM = 1, then op0 is granted.
- op1 with mastlock = 1 for 3 transfers, op0 requesting; ARB_RR = 0 → op1 keeps ownership for all 3 despite priority; op0 is granted the cycle mastlock drops.

Source files
------------

// File: rtl/busmatrix_output_stage_rr2.sv
// ---------------------------------------------------------------------------
// busmatrix_output_stage_rr2
//
// Output stage of an AHB-Lite bus matrix for one slave (MI) port. Two
// input-stage decoders share the port. Each cycle this block picks one of them
// and forwards the winner's address phase to the slave. It remembers who owns
// the data phase so HWDATA comes from the right master, and it reports
// ownership back to each decoder on active_opN.
//
// Parameters:
//   ARB_RR        1 = round-robin between op0/op1, 0 = fixed priority (op0 wins)
//
// Ports:
//   HCLK, HRESETn               clock, asynchronous active-low reset
//   sel_opN                     request from decoder N for this slave port
//   addr/trans/write/size/
//   burst/prot/mastlock_opN     address-phase signals from input stage N
//   wdata_opN                   write data from input stage N (data phase)
//   active_opN                  input N owns this port's address phase (same cycle)
//   HSELM .. HMASTLOCKM         address phase forwarded to the slave
//   HWDATAM                     write data, chosen by the data-phase owner
//   HREADYMUXM                  HREADY to the slave (copy of HREADYOUTM)
//   HREADYOUTM                  slave HREADYOUT
// ---------------------------------------------------------------------------
module busmatrix_output_stage_rr2 #(
    parameter int unsigned ARB_RR = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        sel_op0,
    input  logic        sel_op1,
    input  logic [31:0] addr_op0,
    input  logic [31:0] addr_op1,
    input  logic [1:0]  trans_op0,
    input  logic [1:0]  trans_op1,
    input  logic        write_op0,
    input  logic        write_op1,
    input  logic [2:0]  size_op0,
    input  logic [2:0]  size_op1,
    input  logic [2:0]  burst_op0,
    input  logic [2:0]  burst_op1,
    input  logic [3:0]  prot_op0,
    input  logic [3:0]  prot_op1,
    input  logic        mastlock_op0,
    input  logic        mastlock_op1,
    input  logic [31:0] wdata_op0,
    input  logic [31:0] wdata_op1,
    output logic        active_op0,
    output logic        active_op1,
    output logic        HSELM,
    output logic [31:0] HADDRM,
    output logic [1:0]  HTRANSM,
    output logic        HWRITEM,
    output logic [2:0]  HSIZEM,
    output logic [2:0]  HBURSTM,
    output logic [3:0]  HPROTM,
    output logic        HMASTLOCKM,
    output logic [31:0] HWDATAM,
    output logic        HREADYMUXM,
    input  logic        HREADYOUTM
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_OP0  = 2'b01,
        OWN_OP1  = 2'b10
    } owner_t;

    localparam logic [1:0] TRANS_IDLE = 2'b00;
    localparam logic [1:0] TRANS_BUSY = 2'b01;
    localparam logic [1:0] TRANS_SEQ  = 2'b11;

    owner_t      addr_owner_r;
    owner_t      data_owner_r;
    owner_t      next_owner_s;
    logic        last_grant_r;      // 1'b0 = op0 granted last, 1'b1 = op1

    logic        cur_sel_s;
    logic [1:0]  cur_trans_s;
    logic        cur_lock_s;
    logic        hold_s;
    logic        both_s;

    // Control values of the most recent owner, replayed while nobody is granted
    logic [31:0] held_addr_r;
    logic        held_write_r;
    logic [2:0]  held_size_r;
    logic [2:0]  held_burst_r;
    logic [3:0]  held_prot_r;
    logic        held_lock_r;

    // Request view of whoever currently owns the address phase
    always_comb begin
        cur_sel_s   = 1'b0;
        cur_trans_s = TRANS_IDLE;
        cur_lock_s  = 1'b0;
        case (addr_owner_r)
            OWN_OP0: begin
                cur_sel_s   = sel_op0;
                cur_trans_s = trans_op0;
                cur_lock_s  = mastlock_op0;
            end
            OWN_OP1: begin
                cur_sel_s   = sel_op1;
                cur_trans_s = trans_op1;
                cur_lock_s  = mastlock_op1;
            end
            default: begin
                cur_sel_s   = 1'b0;
                cur_trans_s = TRANS_IDLE;
                cur_lock_s  = 1'b0;
            end
        endcase
    end

    // The owner keeps the port through bursts, locked sequences and unaccepted address phases
    assign hold_s = cur_sel_s & ((cur_trans_s == TRANS_SEQ) | (cur_trans_s == TRANS_BUSY) |
                                 cur_lock_s | ~HREADYOUTM);
    assign both_s = sel_op0 & sel_op1;

    // Next-owner selection; forced to none while reset is asserted so nothing leaks out
    always_comb begin
        next_owner_s = OWN_NONE;
        if (!HRESETn) begin
            next_owner_s = OWN_NONE;
        end else if (hold_s) begin
            next_owner_s = addr_owner_r;
        end else if (both_s) begin
            if (ARB_RR != 0) begin
                next_owner_s = last_grant_r ? OWN_OP0 : OWN_OP1;
            end else begin
                next_owner_s = OWN_OP0;
            end
        end else if (sel_op0) begin
            next_owner_s = OWN_OP0;
        end else if (sel_op1) begin
            next_owner_s = OWN_OP1;
        end else begin
            next_owner_s = OWN_NONE;
        end
    end

    // Address-phase mux toward the slave
    always_comb begin
        HSELM      = 1'b0;
        HTRANSM    = TRANS_IDLE;
        HADDRM     = held_addr_r;
        HWRITEM    = held_write_r;
        HSIZEM     = held_size_r;
        HBURSTM    = held_burst_r;
        HPROTM     = held_prot_r;
        HMASTLOCKM = held_lock_r;
        case (next_owner_s)
            OWN_OP0: begin
                HSELM      = 1'b1;
                HTRANSM    = trans_op0;
                HADDRM     = addr_op0;
                HWRITEM    = write_op0;
                HSIZEM     = size_op0;
                HBURSTM    = burst_op0;
                HPROTM     = prot_op0;
                HMASTLOCKM = mastlock_op0;
            end
            OWN_OP1: begin
                HSELM      = 1'b1;
                HTRANSM    = trans_op1;
                HADDRM     = addr_op1;
                HWRITEM    = write_op1;
                HSIZEM     = size_op1;
                HBURSTM    = burst_op1;
                HPROTM     = prot_op1;
                HMASTLOCKM = mastlock_op1;
            end
            default: begin
                HSELM      = 1'b0;
                HTRANSM    = TRANS_IDLE;
            end
        endcase
    end

    // Write-data mux follows the data-phase owner, not the address-phase owner
    always_comb begin
        HWDATAM = 32'h0000_0000;
        case (data_owner_r)
            OWN_OP0: HWDATAM = wdata_op0;
            OWN_OP1: HWDATAM = wdata_op1;
            default: HWDATAM = 32'h0000_0000;
        endcase
    end

    assign active_op0 = (next_owner_s == OWN_OP0);
    assign active_op1 = (next_owner_s == OWN_OP1);
    assign HREADYMUXM = HREADYOUTM;

    // Ownership and arbitration history advance only when the slave accepts a phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_owner_r <= OWN_NONE;
            data_owner_r <= OWN_NONE;
            last_grant_r <= 1'b1;
        end else if (HREADYOUTM) begin
            addr_owner_r <= next_owner_s;
            data_owner_r <= (HSELM & HTRANSM[1]) ? next_owner_s : OWN_NONE;
            if (both_s & ~hold_s) begin
                last_grant_r <= (next_owner_s == OWN_OP1);
            end
        end
    end

    // Remember the granted master's controls so they stay stable when the port goes idle
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            held_addr_r  <= 32'h0000_0000;
            held_write_r <= 1'b0;
            held_size_r  <= 3'b000;
            held_burst_r <= 3'b000;
            held_prot_r  <= 4'b0000;
            held_lock_r  <= 1'b0;
        end else if (next_owner_s != OWN_NONE) begin
            held_addr_r  <= HADDRM;
            held_write_r <= HWRITEM;
            held_size_r  <= HSIZEM;
            held_burst_r <= HBURSTM;
            held_prot_r  <= HPROTM;
            held_lock_r  <= HMASTLOCKM;
        end
    end

endmodule

// File: tb/tb_busmatrix_output_stage_rr2.sv
// ---------------------------------------------------------------------------
// tb_busmatrix_output_stage_rr2
//
// Drives two instances of the output stage (round-robin and fixed priority)
// from the same pair of requesters and compares every output against a
// behavioural model each cycle, plus targeted checks for the directed
// scenarios (single write, alternation, bursts, wait states, lock, BUSY,
// reset mid-burst), followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_busmatrix_output_stage_rr2;

    logic        HCLK;
    logic        HRESETn;
    logic        ready;

    logic        in_sel   [2];
    logic [31:0] in_addr  [2];
    logic [1:0]  in_trans [2];
    logic        in_write [2];
    logic [2:0]  in_size  [2];
    logic [2:0]  in_burst [2];
    logic [3:0]  in_prot  [2];
    logic        in_lock  [2];
    logic [31:0] in_wdata [2];

    // index 0 = round-robin instance, index 1 = fixed-priority instance
    logic        o_act0   [2];
    logic        o_act1   [2];
    logic        o_hsel   [2];
    logic [31:0] o_haddr  [2];
    logic [1:0]  o_htrans [2];
    logic        o_hwrite [2];
    logic [2:0]  o_hsize  [2];
    logic [2:0]  o_hburst [2];
    logic [3:0]  o_hprot  [2];
    logic        o_hlock  [2];
    logic [31:0] o_hwdata [2];
    logic        o_rdy    [2];

    int n_cmp = 0;
    int n_bad = 0;

    // model state: owners as -1 (none), 0 (op0), 1 (op1)
    int          m_own   [2];
    int          m_data  [2];
    int          m_last  [2];
    int          m_w     [2];
    bit          m_held  [2];
    logic [31:0] m_haddr [2];
    logic        m_hwrite[2];
    logic [2:0]  m_hsize [2];
    logic [2:0]  m_hburst[2];
    logic [3:0]  m_hprot [2];
    logic        m_hlock [2];

    busmatrix_output_stage_rr2 #(.ARB_RR(1)) dut_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .sel_op0(in_sel[0]), .sel_op1(in_sel[1]),
        .addr_op0(in_addr[0]), .addr_op1(in_addr[1]),
        .trans_op0(in_trans[0]), .trans_op1(in_trans[1]),
        .write_op0(in_write[0]), .write_op1(in_write[1]),
        .size_op0(in_size[0]), .size_op1(in_size[1]),
        .burst_op0(in_burst[0]), .burst_op1(in_burst[1]),
        .prot_op0(in_prot[0]), .prot_op1(in_prot[1]),
        .mastlock_op0(in_lock[0]), .mastlock_op1(in_lock[1]),
        .wdata_op0(in_wdata[0]), .wdata_op1(in_wdata[1]),
        .active_op0(o_act0[0]), .active_op1(o_act1[0]),
        .HSELM(o_hsel[0]), .HADDRM(o_haddr[0]), .HTRANSM(o_htrans[0]),
        .HWRITEM(o_hwrite[0]), .HSIZEM(o_hsize[0]), .HBURSTM(o_hburst[0]),
        .HPROTM(o_hprot[0]), .HMASTLOCKM(o_hlock[0]), .HWDATAM(o_hwdata[0]),
        .HREADYMUXM(o_rdy[0]), .HREADYOUTM(ready)
    );

    busmatrix_output_stage_rr2 #(.ARB_RR(0)) dut_fp (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .sel_op0(in_sel[0]), .sel_op1(in_sel[1]),
        .addr_op0(in_addr[0]), .addr_op1(in_addr[1]),
        .trans_op0(in_trans[0]), .trans_op1(in_trans[1]),
        .write_op0(in_write[0]), .write_op1(in_write[1]),
        .size_op0(in_size[0]), .size_op1(in_size[1]),
        .burst_op0(in_burst[0]), .burst_op1(in_burst[1]),
        .prot_op0(in_prot[0]), .prot_op1(in_prot[1]),
        .mastlock_op0(in_lock[0]), .mastlock_op1(in_lock[1]),
        .wdata_op0(in_wdata[0]), .wdata_op1(in_wdata[1]),
        .active_op0(o_act0[1]), .active_op1(o_act1[1]),
        .HSELM(o_hsel[1]), .HADDRM(o_haddr[1]), .HTRANSM(o_htrans[1]),
        .HWRITEM(o_hwrite[1]), .HSIZEM(o_hsize[1]), .HBURSTM(o_hburst[1]),
        .HPROTM(o_hprot[1]), .HMASTLOCKM(o_hlock[1]), .HWDATAM(o_hwdata[1]),
        .HREADYMUXM(o_rdy[1]), .HREADYOUTM(ready)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[inst%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_data[k] = -1; m_last[k] = 1; m_w[k] = -1; m_held[k] = 0;
            m_haddr[k] = 32'h0; m_hwrite[k] = 1'b0; m_hsize[k] = 3'b000;
            m_hburst[k] = 3'b000; m_hprot[k] = 4'b0000; m_hlock[k] = 1'b0;
        end
    endtask

    // Who gets the port this cycle, from the arbitration rules
    task automatic arbitrate(input int k);
        int o;
        int n;
        m_held[k] = 0;
        o = m_own[k];
        n = int'(in_sel[0]) + int'(in_sel[1]);
        if (!HRESETn) begin
            m_w[k] = -1;
        end else if (o >= 0 && in_sel[o] &&
                     (in_trans[o] == 2'b01 || in_trans[o] == 2'b11 || in_lock[o] || !ready)) begin
            m_held[k] = 1;
            m_w[k] = o;
        end else if (n == 2) begin
            m_w[k] = (k == 0) ? 1 - m_last[k] : 0;
        end else if (n == 1) begin
            m_w[k] = in_sel[0] ? 0 : 1;
        end else begin
            m_w[k] = -1;
        end
    endtask

    // Compare all outputs of both instances, sampled mid-cycle
    task automatic sample();
        int w;
        #3;
        for (int k = 0; k < 2; k++) begin
            arbitrate(k);
            w = m_w[k];
            check("active_op0", k, o_act0[k], w == 0);
            check("active_op1", k, o_act1[k], w == 1);
            check("HSELM", k, o_hsel[k], w >= 0);
            check("HREADYMUXM", k, o_rdy[k], ready);
            if (w >= 0) begin
                check("HTRANSM", k, o_htrans[k], in_trans[w]);
                check("HADDRM", k, o_haddr[k], in_addr[w]);
                check("HWRITEM", k, o_hwrite[k], in_write[w]);
                check("HSIZEM", k, o_hsize[k], in_size[w]);
                check("HBURSTM", k, o_hburst[k], in_burst[w]);
                check("HPROTM", k, o_hprot[k], in_prot[w]);
                check("HMASTLOCKM", k, o_hlock[k], in_lock[w]);
            end else begin
                check("HTRANSM", k, o_htrans[k], 2'b00);
                check("HADDRM", k, o_haddr[k], m_haddr[k]);
                check("HWRITEM", k, o_hwrite[k], m_hwrite[k]);
                check("HSIZEM", k, o_hsize[k], m_hsize[k]);
                check("HBURSTM", k, o_hburst[k], m_hburst[k]);
                check("HPROTM", k, o_hprot[k], m_hprot[k]);
                check("HMASTLOCKM", k, o_hlock[k], m_hlock[k]);
            end
            if (m_data[k] >= 0) check("HWDATAM", k, o_hwdata[k], in_wdata[m_data[k]]);
            else                check("HWDATAM", k, o_hwdata[k], 32'h0);
        end
    endtask

    // Clock edge: move the model state forward with the inputs seen before the edge
    task automatic advance();
        int w;
        @(posedge HCLK);
        for (int k = 0; k < 2; k++) begin
            w = m_w[k];
            if (!HRESETn) begin
                model_reset();
            end else begin
                if (w >= 0) begin
                    m_haddr[k] = in_addr[w]; m_hwrite[k] = in_write[w]; m_hsize[k] = in_size[w];
                    m_hburst[k] = in_burst[w]; m_hprot[k] = in_prot[w]; m_hlock[k] = in_lock[w];
                end
                if (ready) begin
                    if (in_sel[0] && in_sel[1] && !m_held[k]) m_last[k] = w;
                    m_own[k] = w;
                    m_data[k] = (w >= 0 && in_trans[w][1]) ? w : -1;
                end
            end
        end
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    task automatic idle_all();
        for (int p = 0; p < 2; p++) begin
            in_sel[p] = 1'b0; in_addr[p] = 32'h0; in_trans[p] = 2'b00; in_write[p] = 1'b0;
            in_size[p] = 3'b000; in_burst[p] = 3'b000; in_prot[p] = 4'b0000;
            in_lock[p] = 1'b0; in_wdata[p] = 32'h0;
        end
        ready = 1'b1;
    endtask

    task automatic drive(input int p, input logic s, input logic [1:0] t,
                         input logic [31:0] a, input logic [2:0] b, input logic l);
        in_sel[p] = s; in_trans[p] = t; in_addr[p] = a; in_burst[p] = b; in_lock[p] = l;
        in_write[p] = 1'b1; in_size[p] = 3'b010; in_prot[p] = 4'b0011 + 4'(p);
    endtask

    initial begin
        model_reset();
        idle_all();
        HRESETn = 1'b0;
        #1;

        // Reset, both idle
        sample();
        for (int k = 0; k < 2; k++) begin
            check("rst_hsel", k, o_hsel[k], 1'b0);
            check("rst_htrans", k, o_htrans[k], 2'b00);
            check("rst_act0", k, o_act0[k], 1'b0);
            check("rst_act1", k, o_act1[k], 1'b0);
            check("rst_hwdata", k, o_hwdata[k], 32'h0);
        end
        advance();
        tick();
        HRESETn = 1'b1;
        tick();

        // op0 single NONSEQ write, data one cycle later
        drive(0, 1'b1, 2'b10, 32'h4000_0010, 3'b000, 1'b0);
        sample();
        for (int k = 0; k < 2; k++) begin
            check("wr_act0", k, o_act0[k], 1'b1);
            check("wr_haddr", k, o_haddr[k], 32'h4000_0010);
        end
        advance();
        idle_all();
        in_wdata[0] = 32'hA5A5_A5A5;
        sample();
        for (int k = 0; k < 2; k++) check("wr_hwdata", k, o_hwdata[k], 32'hA5A5_A5A5);
        advance();

        // Both requesting single NONSEQ every cycle: alternation vs fixed priority
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 2'b10, 32'h1000_0000 + 32'(i), 3'b000, 1'b0);
            drive(1, 1'b1, 2'b10, 32'h2000_0000 + 32'(i), 3'b000, 1'b0);
            sample();
            check("rr_act0", 0, o_act0[0], (i % 2) == 0);
            check("rr_act1", 0, o_act1[0], (i % 2) == 1);
            check("fp_act0", 1, o_act0[1], 1'b1);
            advance();
        end
        idle_all();
        tick();

        // op0 INCR4 burst, op1 requesting from beat 2, granted on beat 5
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(0, 1'b1, (i == 0) ? 2'b10 : 2'b11, 32'h3000_0000 + 32'(4 * i), 3'b011, 1'b0);
            else       drive(0, 1'b0, 2'b00, 32'h0, 3'b000, 1'b0);
            if (i >= 1) drive(1, 1'b1, 2'b10, 32'h5000_0000, 3'b000, 1'b0);
            sample();
            for (int k = 0; k < 2; k++) begin
                if (i < 4) check("burst_hold", k, o_act0[k], 1'b1);
                else       check("burst_next", k, o_act1[k], 1'b1);
            end
            advance();
        end
        idle_all();
        tick();

        // Wait states during op1's data phase while op0 requests
        drive(1, 1'b1, 2'b10, 32'h6000_0000, 3'b000, 1'b0);
        tick();
        drive(1, 1'b1, 2'b10, 32'h6000_0004, 3'b000, 1'b0);
        drive(0, 1'b1, 2'b10, 32'h7000_0000, 3'b000, 1'b0);
        in_wdata[1] = 32'hDEAD_BEEF;
        in_wdata[0] = 32'h1234_5678;
        ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            for (int k = 0; k < 2; k++) begin
                check("ws_act0", k, o_act0[k], 1'b0);
                check("ws_hwdata", k, o_hwdata[k], 32'hDEAD_BEEF);
            end
            advance();
        end
        ready = 1'b1;
        in_sel[1] = 1'b0;
        sample();
        for (int k = 0; k < 2; k++) begin
            check("ws_grant0", k, o_act0[k], 1'b1);
            check("ws_hwdata_last", k, o_hwdata[k], 32'hDEAD_BEEF);
        end
        advance();
        idle_all();
        tick();

        // op1 locked for 3 transfers with op0 requesting; fixed priority instance
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 2'b10, 32'h8000_0000 + 32'(4 * i), 3'b000, i < 3);
            if (i >= 1) drive(0, 1'b1, 2'b10, 32'h9000_0000, 3'b000, 1'b0);
            sample();
            if (i < 3) check("lock_hold", 1, o_act1[1], 1'b1);
            else       check("lock_release", 1, o_act0[1], 1'b1);
            advance();
        end
        idle_all();
        tick();

        // BUSY inside a burst is forwarded and ownership kept
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b1, (i == 0) ? 2'b10 : ((i == 1) ? 2'b01 : 2'b11), 32'hA000_0000, 3'b001, 1'b0);
            if (i >= 1) drive(0, 1'b1, 2'b10, 32'hB000_0000, 3'b000, 1'b0);
            sample();
            for (int k = 0; k < 2; k++) begin
                check("busy_owner", k, o_act1[k], 1'b1);
                if (i == 1) check("busy_htrans", k, o_htrans[k], 2'b01);
            end
            advance();
        end
        idle_all();
        tick();

        // Reset asserted mid-burst
        drive(0, 1'b1, 2'b10, 32'hC000_0000, 3'b011, 1'b0);
        tick();
        drive(0, 1'b1, 2'b11, 32'hC000_0004, 3'b011, 1'b0);
        in_wdata[0] = 32'h5555_AAAA;
        tick();
        drive(0, 1'b1, 2'b11, 32'hC000_0008, 3'b011, 1'b0);
        HRESETn = 1'b0;
        model_reset();
        sample();
        for (int k = 0; k < 2; k++) begin
            check("mrst_hsel", k, o_hsel[k], 1'b0);
            check("mrst_act0", k, o_act0[k], 1'b0);
            check("mrst_haddr", k, o_haddr[k], 32'h0);
            check("mrst_hwdata", k, o_hwdata[k], 32'h0);
        end
        advance();
        HRESETn = 1'b1;
        idle_all();
        tick();

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            for (int p = 0; p < 2; p++) begin
                in_sel[p]   = ($urandom_range(0, 9) < 7);
                in_trans[p] = 2'($urandom_range(0, 3));
                in_addr[p]  = $urandom;
                in_write[p] = 1'($urandom_range(0, 1));
                in_size[p]  = 3'($urandom_range(0, 7));
                in_burst[p] = 3'($urandom_range(0, 7));
                in_prot[p]  = 4'($urandom_range(0, 15));
                in_lock[p]  = ($urandom_range(0, 7) == 0);
                in_wdata[p] = $urandom;
            end
            ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
